// File: rtl/fifo_pkg.sv
// fifo_sync_param shared package: mode constants and a width helper.
// Imported by the FIFO interface, memory and top.
package fifo_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  // Portable ceil(log2(n)) for tools without $clog2
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_sync_param_if.sv
// Handshake and status bundle between a FIFO user and fifo_sync_param.
// master = producer/consumer side, slave = FIFO side.
interface fifo_sync_param_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
);
  import fifo_pkg::*;

  localparam int CW = clog2(DEPTH) + 1;

  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic              flush;
  logic              clr_err;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [CW-1:0]     count;
  logic              overflow;
  logic              underflow;

  modport master (
    output wr_en, wr_data, rd_en,
    output flush, clr_err,
    input  rd_data, rd_valid,
    input  full, empty,
    input  almost_full, almost_empty,
    input  count, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    input  flush, clr_err,
    output rd_data, rd_valid,
    output full, empty,
    output almost_full, almost_empty,
    output count, overflow, underflow
  );

endinterface

// File: rtl/fifo_mem.sv
// FIFO storage: DEPTH x DATA_W array, sync write, async read.
// Kept separate so a RAM macro can replace it.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with FWFT or registered read,
// programmable level flags, flush and sticky error flags.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = FIFO_MODE_FWFT
) (
  input  logic            clk,
  input  logic            rst,
  fifo_sync_param_if.slave bus
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("fifo_sync_param: DEPTH must be a power of two >= 2");
  end
  if ((AF_LEVEL < 1) || (AF_LEVEL > DEPTH)) begin : g_bad_af
    $error("fifo_sync_param: AF_LEVEL out of range");
  end
  if ((AE_LEVEL < 0) || (AE_LEVEL >= DEPTH)) begin : g_bad_ae
    $error("fifo_sync_param: AE_LEVEL out of range");
  end

  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              r_full;
  logic              r_empty;
  logic              r_af;
  logic              r_ae;
  logic              r_ovf;
  logic              r_udf;

  logic              w_rd_acc;
  logic              w_wr_acc;
  logic              w_ovf_set;
  logic              w_udf_set;
  logic [CW-1:0]     w_count_nx;
  logic [DATA_W-1:0] w_mem_rd;
  logic [DATA_W-1:0] w_rd_data;
  logic              w_rd_valid;

  // Flush swallows same-cycle requests without flagging errors
  always_comb begin
    w_rd_acc  = 1'b0;
    w_wr_acc  = 1'b0;
    w_ovf_set = 1'b0;
    w_udf_set = 1'b0;
    if (!bus.flush) begin
      w_rd_acc  = bus.rd_en & ~r_empty;
      w_wr_acc  = bus.wr_en & (~r_full | w_rd_acc);
      w_ovf_set = bus.wr_en & ~w_wr_acc;
      w_udf_set = bus.rd_en & ~w_rd_acc;
    end
  end

  always_comb begin
    w_count_nx = r_count;
    if (bus.flush) begin
      w_count_nx = '0;
    end else begin
      w_count_nx = r_count + CW'(w_wr_acc) - CW'(w_rd_acc);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_af     <= 1'b0;
      r_ae     <= 1'b1;
    end else begin
      if (bus.flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_wr_acc) r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_rd_acc) r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= w_count_nx;
      r_full  <= (w_count_nx == CW'(DEPTH));
      r_empty <= (w_count_nx == '0);
      r_af    <= (w_count_nx >= CW'(AF_LEVEL));
      r_ae    <= (w_count_nx <= CW'(AE_LEVEL));
    end
  end

  // Set beats clear when both happen in one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      r_ovf <= w_ovf_set | (r_ovf & ~bus.clr_err);
      r_udf <= w_udf_set | (r_udf & ~bus.clr_err);
    end
  end

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_wr_acc),
    .i_waddr (r_wr_ptr),
    .i_wdata (bus.wr_data),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_mem_rd)
  );

  if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
    // Head is visible directly; forced to 0 while empty
    assign w_rd_data  = r_empty ? '0 : w_mem_rd;
    assign w_rd_valid = ~r_empty;
  end else begin : g_std
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_valid;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_rd_data  <= '0;
        r_rd_valid <= 1'b0;
      end else begin
        r_rd_valid <= w_rd_acc;
        if (w_rd_acc) r_rd_data <= w_mem_rd;
      end
    end

    assign w_rd_data  = r_rd_data;
    assign w_rd_valid = r_rd_valid;
  end

  assign bus.rd_data      = w_rd_data;
  assign bus.rd_valid     = w_rd_valid;
  assign bus.full         = r_full;
  assign bus.empty        = r_empty;
  assign bus.almost_full  = r_af;
  assign bus.almost_empty = r_ae;
  assign bus.count        = r_count;
  assign bus.overflow     = r_ovf;
  assign bus.underflow    = r_udf;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench for fifo_sync_param in FWFT and registered-read modes.
// Inputs change 1ns after the rising edge; outputs are checked there too.
module tb_fifo_sync_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  fifo_sync_param_if #(.DATA_W(8), .DEPTH(16)) fa ();
  fifo_sync_param_if #(.DATA_W(8), .DEPTH(16)) fs ();

  fifo_sync_param #(
    .DATA_W(8), .DEPTH(16), .AF_LEVEL(12),
    .AE_LEVEL(2), .FWFT(1)
  ) u_fwft (
    .clk(clk), .rst(rst), .bus(fa.slave)
  );

  fifo_sync_param #(
    .DATA_W(8), .DEPTH(16), .AF_LEVEL(12),
    .AE_LEVEL(2), .FWFT(0)
  ) u_std (
    .clk(clk), .rst(rst), .bus(fs.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    fa.wr_en = 0; fa.rd_en = 0; fa.flush = 0;
    fa.clr_err = 0; fa.wr_data = 8'h00;
    fs.wr_en = 0; fs.rd_en = 0; fs.flush = 0;
    fs.clr_err = 0; fs.wr_data = 8'h00;
  endtask

  // flags packed as {empty,ae,full,af,rd_valid,ovf,udf}
  task automatic test_reset();
    logic [6:0] f;
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    f = {fa.empty, fa.almost_empty, fa.full, fa.almost_full,
         fa.rd_valid, fa.overflow, fa.underflow};
    n_total++;
    if (f !== 7'b1100000)
      $display("FAIL reset_flags_fwft got %b want 1100000", f);
    else n_pass++;
    n_total++;
    if (fa.count !== 5'd0)
      $display("FAIL reset_count got %0d want 0", fa.count);
    else n_pass++;
    n_total++;
    if (fa.rd_data !== 8'h00)
      $display("FAIL reset_rd_data got %h want 00", fa.rd_data);
    else n_pass++;
    f = {fs.empty, fs.almost_empty, fs.full, fs.almost_full,
         fs.rd_valid, fs.overflow, fs.underflow};
    n_total++;
    if (f !== 7'b1100000)
      $display("FAIL reset_flags_std got %b want 1100000", f);
    else n_pass++;
    n_total++;
    if (fs.rd_data !== 8'h00)
      $display("FAIL reset_rd_data_std got %h want 00", fs.rd_data);
    else n_pass++;
  endtask

  task automatic test_fwft_latency();
    fa.wr_en = 1; fa.wr_data = 8'hA5;
    tick();
    fa.wr_en = 0;
    n_total++;
    if (fa.rd_data !== 8'hA5 || fa.rd_valid !== 1'b1)
      $display("FAIL fwft_lat got %h/%b want a5/1",
               fa.rd_data, fa.rd_valid);
    else n_pass++;
    fa.rd_en = 1;
    tick();
    fa.rd_en = 0;
    n_total++;
    if (fa.empty !== 1'b1 || fa.rd_valid !== 1'b0)
      $display("FAIL fwft_pop got e=%b v=%b want 1/0",
               fa.empty, fa.rd_valid);
    else n_pass++;
  endtask

  task automatic test_fill_drain(input logic [7:0] base);
    logic [7:0] exp;
    for (int i = 0; i < 16; i++) begin
      fa.wr_en = 1; fa.wr_data = base + 8'(i);
      tick();
      n_total++;
      if (fa.count !== 5'(i + 1) ||
          fa.almost_full !== (i + 1 >= 12) ||
          fa.almost_empty !== (i + 1 <= 2))
        $display("FAIL fill_%0d got c=%0d af=%b ae=%b", i,
                 fa.count, fa.almost_full, fa.almost_empty);
      else n_pass++;
    end
    fa.wr_data = 8'hEE;
    tick();
    fa.wr_en = 0;
    n_total++;
    if (fa.full !== 1'b1 || fa.overflow !== 1'b1 ||
        fa.count !== 5'd16)
      $display("FAIL overflow got f=%b o=%b c=%0d want 1/1/16",
               fa.full, fa.overflow, fa.count);
    else n_pass++;
    for (int i = 0; i < 16; i++) begin
      exp = base + 8'(i);
      n_total++;
      if (fa.rd_data !== exp || fa.rd_valid !== 1'b1)
        $display("FAIL drain_%0d got %h want %h", i,
                 fa.rd_data, exp);
      else n_pass++;
      fa.rd_en = 1;
      tick();
      fa.rd_en = 0;
    end
    n_total++;
    if (fa.empty !== 1'b1 || fa.underflow !== 1'b0)
      $display("FAIL drain_end got e=%b u=%b want 1/0",
               fa.empty, fa.underflow);
    else n_pass++;
    fa.clr_err = 1;
    tick();
    fa.clr_err = 0;
    n_total++;
    if (fa.overflow !== 1'b0)
      $display("FAIL clr_ovf got %b want 0", fa.overflow);
    else n_pass++;
  endtask

  task automatic test_full_rw();
    logic [7:0] exp;
    for (int i = 0; i < 16; i++) begin
      fa.wr_en = 1; fa.wr_data = 8'h30 + 8'(i);
      tick();
    end
    fa.rd_en = 1; fa.wr_data = 8'h77;
    tick();
    idle();
    n_total++;
    if (fa.count !== 5'd16 || fa.overflow !== 1'b0 ||
        fa.full !== 1'b1)
      $display("FAIL full_rw got c=%0d o=%b f=%b want 16/0/1",
               fa.count, fa.overflow, fa.full);
    else n_pass++;
    for (int i = 0; i < 16; i++) begin
      exp = (i < 15) ? 8'h31 + 8'(i) : 8'h77;
      n_total++;
      if (fa.rd_data !== exp)
        $display("FAIL full_rw_drain_%0d got %h want %h", i,
                 fa.rd_data, exp);
      else n_pass++;
      fa.rd_en = 1;
      tick();
      fa.rd_en = 0;
    end
  endtask

  task automatic test_std_read();
    fs.wr_en = 1; fs.wr_data = 8'h11;
    tick();
    fs.wr_data = 8'h22;
    tick();
    fs.wr_en = 0;
    n_total++;
    if (fs.rd_valid !== 1'b0 || fs.count !== 5'd2)
      $display("FAIL std_idle got v=%b c=%0d want 0/2",
               fs.rd_valid, fs.count);
    else n_pass++;
    fs.rd_en = 1;
    tick();
    n_total++;
    if (fs.rd_valid !== 1'b1 || fs.rd_data !== 8'h11)
      $display("FAIL std_rd1 got %b/%h want 1/11",
               fs.rd_valid, fs.rd_data);
    else n_pass++;
    tick();
    fs.rd_en = 0;
    n_total++;
    if (fs.rd_valid !== 1'b1 || fs.rd_data !== 8'h22)
      $display("FAIL std_rd2 got %b/%h want 1/22",
               fs.rd_valid, fs.rd_data);
    else n_pass++;
    tick();
    n_total++;
    if (fs.rd_valid !== 1'b0 || fs.rd_data !== 8'h22 ||
        fs.underflow !== 1'b0)
      $display("FAIL std_hold got v=%b d=%h u=%b want 0/22/0",
               fs.rd_valid, fs.rd_data, fs.underflow);
    else n_pass++;
    fs.rd_en = 1;
    tick();
    fs.rd_en = 0;
    n_total++;
    if (fs.underflow !== 1'b1 || fs.rd_valid !== 1'b0)
      $display("FAIL std_udf got u=%b v=%b want 1/0",
               fs.underflow, fs.rd_valid);
    else n_pass++;
    fs.clr_err = 1;
    tick();
    n_total++;
    if (fs.underflow !== 1'b0)
      $display("FAIL std_clr got %b want 0", fs.underflow);
    else n_pass++;
    fs.rd_en = 1;
    tick();
    fs.rd_en = 0; fs.clr_err = 0;
    n_total++;
    if (fs.underflow !== 1'b1)
      $display("FAIL set_wins got %b want 1", fs.underflow);
    else n_pass++;
    fs.clr_err = 1;
    tick();
    fs.clr_err = 0;
  endtask

  task automatic test_flush();
    fa.wr_en = 1; fa.rd_en = 1; fa.wr_data = 8'h01;
    tick();
    fa.rd_en = 0;
    n_total++;
    if (fa.count !== 5'd1 || fa.underflow !== 1'b1 ||
        fa.rd_data !== 8'h01)
      $display("FAIL empty_wr_rd got c=%0d u=%b d=%h",
               fa.count, fa.underflow, fa.rd_data);
    else n_pass++;
    fa.clr_err = 1;
    for (int i = 0; i < 4; i++) begin
      fa.wr_data = 8'h02 + 8'(i);
      tick();
      fa.clr_err = 0;
    end
    n_total++;
    if (fa.count !== 5'd5 || fa.underflow !== 1'b0)
      $display("FAIL pre_flush got c=%0d u=%b want 5/0",
               fa.count, fa.underflow);
    else n_pass++;
    fa.flush = 1; fa.wr_en = 1; fa.rd_en = 1;
    tick();
    idle();
    n_total++;
    if (fa.count !== 5'd0 || fa.empty !== 1'b1 ||
        fa.rd_valid !== 1'b0 || fa.overflow !== 1'b0 ||
        fa.underflow !== 1'b0)
      $display("FAIL flush got c=%0d e=%b v=%b o=%b u=%b",
               fa.count, fa.empty, fa.rd_valid,
               fa.overflow, fa.underflow);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    fs.wr_en = 1; fs.wr_data = 8'h5A;
    tick();
    fs.wr_en = 0; fs.rd_en = 1;
    tick();
    fs.rd_en = 0;
    n_total++;
    if (fs.rd_data !== 8'h5A || fs.rd_valid !== 1'b1)
      $display("FAIL pre_rst_std got %h/%b want 5a/1",
               fs.rd_data, fs.rd_valid);
    else n_pass++;
    fa.wr_en = 1;
    for (int i = 0; i < 3; i++) begin
      fa.wr_data = 8'hC0 + 8'(i);
      tick();
    end
    fs.wr_en = 1; fs.rd_en = 1;
    rst = 1'b1;
    #2;
    n_total++;
    if (fa.count !== 5'd0 || fa.empty !== 1'b1 ||
        fa.rd_valid !== 1'b0 || fa.rd_data !== 8'h00)
      $display("FAIL rst_mid_fwft got c=%0d e=%b v=%b d=%h",
               fa.count, fa.empty, fa.rd_valid, fa.rd_data);
    else n_pass++;
    n_total++;
    if (fs.rd_data !== 8'h00 || fs.rd_valid !== 1'b0)
      $display("FAIL rst_mid_std got %h/%b want 00/0",
               fs.rd_data, fs.rd_valid);
    else n_pass++;
    idle();
    tick();
    rst = 1'b0;
    tick();
    n_total++;
    if (fa.count !== 5'd0 || fs.count !== 5'd0 ||
        fa.almost_empty !== 1'b1)
      $display("FAIL post_rst got %0d/%0d ae=%b want 0/0/1",
               fa.count, fs.count, fa.almost_empty);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_fwft_latency();
    test_fill_drain(8'h00);
    test_fill_drain(8'h40);
    test_full_rw();
    test_std_read();
    test_flush();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
